weight_bank_sequencer: RTL
==========================

# weight_bank_sequencer

Double-buffered weight controller for the systolic MAC row: fills a shadow weight bank row by row over a valid/ready stream while the active bank drives a compute layer. It swaps banks on a layer request, so the next tile's weights load while the current layer runs. It is the parametrised successor to the single-bank load/layer mode controller and sits between the weight fetch path and the MAC array enables.

## Interface
Parameters:
- N_MACS, 4, MAC columns; width of mac_en and col_mask
- N_ROWS, 4, weight rows per tile; width of load_row_en; must be ≥1
- LEN_W, 8, width of layer_cycles

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: begin filling the shadow bank
- w_valid  in  1  weight beat present
- w_ready  out  1  sequencer accepts a beat
- load_row_en  out  N_ROWS  one-hot row write strobe into the shadow bank
- load_bank  out  1  bank being written; always ~active_bank
- loaded  out  1  shadow bank holds a complete tile
- layer_req  in  1  level; request to start a layer
- layer_cycles  in  LEN_W  layer length; sampled on acceptance
- col_mask  in  N_MACS  columns enabled for the layer; sampled on acceptance
- layer_ack  out  1  one-cycle pulse on acceptance
- active_bank  out  1  bank feeding the MACs
- mac_en  out  N_MACS  latched col_mask while the layer runs, else 0
- done  out  1  one-cycle pulse on the last compute cycle
- busy  out  1  loader filling OR layer running

## Operation
- Loader FSM: L_IDLE (shadow empty), L_FILL, L_FULL.
  - L_IDLE + start → L_FILL, row_idx = 0. start is ignored in other states.
  - L_FILL: w_ready = 1.
    - Beat = w_valid & w_ready.
    - On a beat, load_row_en = 1 << row_idx and row_idx increments.
    - On the beat at row_idx = N_ROWS-1: → L_FULL, row_idx = 0.
  - Outside a beat, load_row_en = 0.
  - loaded = (state == L_FULL).
- Compute FSM: C_IDLE, C_RUN, with down-counter cnt.
- Acceptance condition: layer_req & L_FULL & (C_IDLE or cnt == 1).
- On acceptance:
  - layer_ack pulses and active_bank toggles.
  - Loader → L_IDLE.
  - Compute → C_RUN with cnt = max(layer_cycles, 1); col_mask is latched.
- C_RUN:
  - mac_en = latched mask.
  - cnt decrements each cycle.
  - When cnt == 1: done pulses; → C_IDLE unless an acceptance occurs in the same cycle, in which case it reloads and stays in C_RUN.
- Simultaneous events:
  - start and an acceptance in the same cycle: the loader is in L_FULL, so start is dropped. The loader is in L_IDLE on the next cycle.
  - layer_req while not loaded: held off with no ack. The request stays pending as long as it is held.
  - Loader activity never affects a running layer. active_bank changes only on acceptance.
- Widths: cnt is LEN_W bits. row_idx is max($clog2(N_ROWS),1) bits. No wrap beyond N_ROWS-1.

## Timing
- Reset (synchronous), effective at the next edge:
  - Both FSMs idle, row_idx = 0, cnt = 0.
  - active_bank = 0, load_bank = 1.
  - w_ready, load_row_en, loaded, layer_ack, mac_en, done, busy all 0.
  - The mask latch clears.
- Reset mid-load or mid-layer aborts with no done pulse; a partially written tile is discarded.
- start sampled at edge k → w_ready = 1 from cycle k+1.
- Minimum fill time is N_ROWS cycles; loaded = 1 the cycle after the last beat.
- Acceptance at edge k → layer_ack in cycle k. Then from cycle k+1: mac_en active and active_bank toggled.
- mac_en is active for exactly max(layer_cycles,1) cycles; done coincides with the final one.
- Back-to-back layers (req held, shadow full) run with zero bubble cycles.
- All outputs are registered-state decodes. layer_ack, load_row_en and w_ready are combinational from state and inputs.

## Structure
- Package weight_seq_pkg:
  - Loader and compute state encodings.
  - Row-index width helper function.
- Sub-module weight_row_loader: loader FSM, row counter, valid/ready, one-hot strobe, loaded.
- The top level holds the compute FSM, bank toggle and mask latch.

## Test plan
- Reset, then start, then 4 back-to-back beats (N_ROWS=4) → load_row_en 0001, 0010, 0100, 1000 on consecutive cycles; loaded = 1 in the next cycle; load_bank = 1.
- w_valid toggling 1,0,1,0,… → row_idx advances only on beats; 4 beats span 7 cycles.
- Loaded, layer_req = 1, layer_cycles = 5, col_mask = 0110 → ack; active_bank = 1; mac_en = 0110 for 5 cycles; done on the 5th; loaded = 0.
- Refill during the layer, then layer_req held → second ack on the first layer's last cycle; done and ack coincide; mac_en is continuous; active_bank returns to 0.
- layer_req without loaded → no ack for 10 cycles; start during L_FILL is ignored (row_idx unchanged); layer_cycles = 0 → 1-cycle layer.
- Assert rst at beat 2 and again mid-layer → all outputs 0, active_bank = 0, no done pulse.

Source files
------------

// File: rtl/weight_seq_pkg.sv
// Shared state encodings and sizing helper for the double-buffered weight bank sequencer.
package weight_seq_pkg;

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_FILL = 2'd1,
        L_FULL = 2'd2
    } load_state_t;

    typedef enum logic {
        C_IDLE = 1'b0,
        C_RUN  = 1'b1
    } comp_state_t;

    // A single-row tile still needs a 1-bit row index.
    function automatic int row_idx_w(input int n_rows);
        return (n_rows > 1) ? $clog2(n_rows) : 1;
    endfunction

endpackage

// File: rtl/weight_row_loader.sv
// Shadow-bank fill controller: accepts one weight row per valid/ready beat and
// reports a complete tile until the compute side takes the bank.
//   state  | meaning
//   L_IDLE | shadow bank empty, waiting for start
//   L_FILL | accepting beats, one row per beat
//   L_FULL | complete tile held, waiting for a layer to take it
module weight_row_loader
    import weight_seq_pkg::*;
#(
    parameter int N_ROWS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              w_valid,
    input  logic              release_bank,
    output logic              w_ready,
    output logic [N_ROWS-1:0] load_row_en,
    output logic              loaded,
    output logic              filling
);
    localparam int RW = row_idx_w(N_ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(N_ROWS - 1);

    load_state_t   state, state_next;
    logic [RW-1:0] row_idx, row_idx_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= L_IDLE;
            row_idx <= '0;
        end else begin
            state   <= state_next;
            row_idx <= row_idx_next;
        end
    end

    always_comb begin
        state_next   = state;
        row_idx_next = row_idx;
        w_ready      = 1'b0;
        load_row_en  = '0;
        unique case (state)
            L_IDLE: begin
                if (start) begin
                    state_next   = L_FILL;
                    row_idx_next = '0;
                end
            end
            L_FILL: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    load_row_en = N_ROWS'(1) << row_idx;
                    if (row_idx == LAST_ROW) begin
                        state_next   = L_FULL;
                        row_idx_next = '0;
                    end else begin
                        row_idx_next = row_idx + RW'(1);
                    end
                end
            end
            L_FULL: begin
                // start is deliberately ignored here, even in the release cycle.
                if (release_bank) state_next = L_IDLE;
            end
            default: state_next = L_IDLE;
        endcase
    end

    assign loaded  = (state == L_FULL);
    assign filling = (state == L_FILL);

endmodule

// File: rtl/weight_bank_sequencer.sv
// Double-buffered weight controller: compute FSM, bank toggle and column mask latch,
// with the shadow-bank loader as a sub-module.
//   state  | meaning
//   C_IDLE | no layer running, MACs disabled
//   C_RUN  | layer running, cnt = cycles left including this one
module weight_bank_sequencer
    import weight_seq_pkg::*;
#(
    parameter int N_MACS = 4,
    parameter int N_ROWS = 4,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              w_valid,
    output logic              w_ready,
    output logic [N_ROWS-1:0] load_row_en,
    output logic              load_bank,
    output logic              loaded,
    input  logic              layer_req,
    input  logic [LEN_W-1:0]  layer_cycles,
    input  logic [N_MACS-1:0] col_mask,
    output logic              layer_ack,
    output logic              active_bank,
    output logic [N_MACS-1:0] mac_en,
    output logic              done,
    output logic              busy
);
    comp_state_t       c_state, c_state_next;
    logic [LEN_W-1:0]  cnt, cnt_next;
    logic [N_MACS-1:0] mask, mask_next;
    logic              bank_next;
    logic              filling;
    logic              last_cycle;
    logic              accept;

    weight_row_loader #(
        .N_ROWS(N_ROWS)
    ) u_loader (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .w_valid     (w_valid),
        .release_bank(accept),
        .w_ready     (w_ready),
        .load_row_en (load_row_en),
        .loaded      (loaded),
        .filling     (filling)
    );

    assign last_cycle = (c_state == C_RUN) && (cnt == LEN_W'(1));
    // Accepting on the last cycle of a running layer gives zero-bubble back-to-back layers.
    assign accept     = layer_req && loaded && ((c_state == C_IDLE) || last_cycle);

    always_ff @(posedge clk) begin
        if (rst) begin
            c_state     <= C_IDLE;
            cnt         <= '0;
            mask        <= '0;
            active_bank <= 1'b0;
        end else begin
            c_state     <= c_state_next;
            cnt         <= cnt_next;
            mask        <= mask_next;
            active_bank <= bank_next;
        end
    end

    always_comb begin
        c_state_next = c_state;
        cnt_next     = cnt;
        mask_next    = mask;
        bank_next    = active_bank;
        if (accept) begin
            c_state_next = C_RUN;
            cnt_next     = (layer_cycles == '0) ? LEN_W'(1) : layer_cycles;
            mask_next    = col_mask;
            bank_next    = ~active_bank;
        end else if (c_state == C_RUN) begin
            cnt_next = cnt - LEN_W'(1);
            if (last_cycle) c_state_next = C_IDLE;
        end
    end

    assign layer_ack = accept;
    assign load_bank = ~active_bank;
    assign mac_en    = (c_state == C_RUN) ? mask : '0;
    assign done      = last_cycle;
    assign busy      = filling || (c_state == C_RUN);

endmodule
